// File: rtl/expr_pipe_lanes_if.sv
// Handshake bundle for expr_pipe_lanes: request side (in_*) and response side (out_*).
// slave is the block itself; master is whoever drives requests and consumes results.
interface expr_pipe_lanes_if #(
  parameter int W = 4,
  parameter int N = 2
);
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic           in_signed;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_y;
  logic [N-1:0]   out_zero;
  logic           out_par;
  logic           out_err;

  modport master (
    output in_valid, in_op, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_par, out_err
  );

  modport slave (
    input  in_valid, in_op, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_par, out_err
  );
endinterface

// File: rtl/expr_pipe_lanes.sv
// Two-stage valid/ready pipeline evaluating one opcode-selected expression per
// transaction across N independent W-bit lanes, signed or unsigned per transaction.

module expr_lane #(
  parameter int W   = 4,
  parameter int SHW = 2
) (
  input  logic [3:0]   op,
  input  logic         sgn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XNR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_LT  = 4'd7,
    OP_LE  = 4'd8, OP_EQ  = 4'd9, OP_MUL = 4'd10, OP_MIN = 4'd11,
    OP_MAX = 4'd12
  } op_e;

  logic [SHW-1:0]      s;
  logic signed [W-1:0] sa;
  logic                lt, eq;
  logic [W-1:0]        prod;

  assign s    = b[SHW-1:0];
  assign sa   = a;
  assign eq   = (a == b);
  assign lt   = sgn ? ($signed(a) < $signed(b)) : (a < b);
  // low W bits of a*b are identical for signed and unsigned operands
  assign prod = a * b;

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XNR: y = a ~^ b;
      OP_SHL: y = a << s;
      // shifts of s >= W fall out naturally as 0 or sign fill
      OP_SHR: if (sgn) y = sa >>> s;
              else     y = a >> s;
      OP_LT:  y = {{(W-1){1'b0}}, lt};
      OP_LE:  y = {{(W-1){1'b0}}, lt | eq};
      OP_EQ:  y = {{(W-1){1'b0}}, eq};
      OP_MUL: y = prod;
      OP_MIN: y = lt ? a : b;
      OP_MAX: y = lt ? b : a;
      default: y = '0;
    endcase
  end
endmodule

module expr_pipe_lanes #(
  parameter  int W   = 4,
  parameter  int N   = 2,
  localparam int SHW = $clog2(W)
) (
  input logic           clk,
  input logic           rst_n,
  expr_pipe_lanes_if.slave io
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [3:0]          op;
    logic                sgn;
    logic [N-1:0][W-1:0] a;
    logic [N-1:0][W-1:0] b;
  } req_t;

  typedef struct packed {
    logic [N-1:0][W-1:0] y;
    logic [N-1:0]        zero;
    logic                par;
    logic                err;
  } rsp_t;

  logic [STAGES:1]     vld_pipe;
  logic                en1, en2;
  req_t                req_d, s1;
  rsp_t                rsp_d, s2;
  logic [N-1:0][W-1:0] y_d;

  assign en2         = !vld_pipe[2] | io.out_ready;
  assign en1         = !vld_pipe[1] | en2;
  assign io.in_ready = en1;

  always_comb begin
    req_d     = '0;
    req_d.op  = io.in_op;
    req_d.sgn = io.in_signed;
    req_d.a   = io.in_a;
    req_d.b   = io.in_b;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    expr_lane #(.W(W), .SHW(SHW)) u_lane (
      .op  (s1.op),
      .sgn (s1.sgn),
      .a   (s1.a[i]),
      .b   (s1.b[i]),
      .y   (y_d[i])
    );
  end

  always_comb begin
    rsp_d     = '0;
    rsp_d.y   = y_d;
    rsp_d.par = ^y_d;
    rsp_d.err = (s1.op >= 4'd13);
    for (int k = 0; k < N; k++) rsp_d.zero[k] = ~|y_d[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (en1) begin
        vld_pipe[1] <= io.in_valid;
        if (io.in_valid) s1 <= req_d;
      end
      // S2 only loads on a real transaction so outputs hold while idle or stalled
      if (en2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= rsp_d;
      end
    end
  end

  assign io.out_valid = vld_pipe[2];
  assign io.out_y     = s2.y;
  assign io.out_zero  = s2.zero;
  assign io.out_par   = s2.par;
  assign io.out_err   = s2.err;
endmodule

// File: tb/tb_expr_pipe_lanes.sv
// Scoreboard bench for expr_pipe_lanes: directed cases, backpressure, mid-flight
// reset and randomized traffic against an integer-arithmetic reference model.
module tb_expr_pipe_lanes;
  localparam int W   = 4;
  localparam int N   = 2;
  localparam int SHW = $clog2(W);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  expr_pipe_lanes_if #(.W(W), .N(N)) bus ();
  expr_pipe_lanes #(.W(W), .N(N)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  expr_pipe_lanes_if #(.W(5), .N(1)) bus5 ();
  expr_pipe_lanes #(.W(5), .N(1)) dut5 (.clk(clk), .rst_n(rst_n), .io(bus5));

  typedef struct {
    logic [N*W-1:0] y;
    logic [N-1:0]   zero;
    logic           par;
    logic           err;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;
  int   acc_cnt = 0;
  bit   done = 0;
  logic stall_prev = 1'b0;
  logic [N*W+N+2:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: lanes as plain integers, results reduced mod 2^W.
  function automatic int sx(input logic [W-1:0] v, input bit sgn);
    if (sgn && v[W-1]) return int'(v) - (1 << W);
    return int'(v);
  endfunction

  function automatic logic [W-1:0] ref_lane(input int op, input bit sgn,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, s, r;
    ia = sx(a, sgn);
    ib = sx(b, sgn);
    s  = int'(b) % (1 << SHW);
    case (op)
      0:  r = ia + ib;
      1:  r = ia - ib;
      2:  r = int'(a & b);
      3:  r = int'(a | b);
      4:  r = ~int'(a ^ b);
      5:  r = (s >= W) ? 0 : ia * (1 << s);
      6:  r = (s >= W) ? ((ia < 0) ? -1 : 0) : (ia >>> s);
      7:  r = int'(ia < ib);
      8:  r = int'(ia <= ib);
      9:  r = int'(ia == ib);
      10: r = ia * ib;
      11: r = (ia < ib) ? ia : ib;
      12: r = (ia < ib) ? ib : ia;
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  function automatic exp_t ref_txn(input logic [3:0] op, input logic sgn,
                                   input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    exp_t e;
    logic [W-1:0] l;
    e.y = '0;
    e.zero = '0;
    for (int i = 0; i < N; i++) begin
      l = ref_lane(int'(op), sgn, a[i*W +: W], b[i*W +: W]);
      e.y[i*W +: W] = l;
      e.zero[i] = (l == '0);
    end
    e.par = ^e.y;
    e.err = (op >= 4'd13);
    return e;
  endfunction

  // Monitor: pops on every output handshake and checks holds during stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev)
        chk("hold_stable", {bus.out_valid, bus.out_y, bus.out_zero, bus.out_par, bus.out_err}, held);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y=%0h with no pending transaction", bus.out_y);
        end else begin
          e_m = sb.pop_front();
          chk("out_y", bus.out_y, e_m.y);
          chk("out_zero", bus.out_zero, e_m.zero);
          chk("out_par", bus.out_par, e_m.par);
          chk("out_err", bus.out_err, e_m.err);
        end
        hs_cnt++;
      end
    end
    stall_prev <= rst_n && bus.out_valid && !bus.out_ready;
    held <= {bus.out_valid, bus.out_y, bus.out_zero, bus.out_par, bus.out_err};
  end

  task automatic send(input logic [3:0] op, input logic sgn,
                      input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_signed = sgn;
    bus.in_a = a;
    bus.in_b = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles expected 1");
        return;
      end
    end
    sb.push_back(ref_txn(op, sgn, a, b));
    acc_cnt++;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0, h0, guard;
    bus.in_valid = 0; bus.in_op = 0; bus.in_signed = 0; bus.in_a = 0; bus.in_b = 0;
    bus.out_ready = 1;
    bus5.in_valid = 0; bus5.in_op = 0; bus5.in_signed = 0; bus5.in_a = 0; bus5.in_b = 0;
    bus5.out_ready = 1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_flags", {bus.out_zero, bus.out_par, bus.out_err}, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // LT mode and latency: result visible two edges after the request is driven
    send(4'd7, 1'b0, 8'hF0, 8'h11);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("latency_edge1", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("latency_edge2", bus.out_valid, 1);
    send(4'd7, 1'b1, 8'hF0, 8'h11);
    // SHR / SHL, MUL and ADD wrap, reserved opcode followed by a valid one
    send(4'd6, 1'b1, 8'h88, 8'h11);
    send(4'd6, 1'b0, 8'h88, 8'h11);
    send(4'd5, 1'b0, 8'h88, 8'h11);
    send(4'd10, 1'b1, 8'h77, 8'h33);
    send(4'd0, 1'b0, 8'hF9, 8'h18);
    send(4'd14, 1'b0, 8'hFF, 8'hFF);
    send(4'd9, 1'b1, 8'h3C, 8'h3D);
    idle();
    repeat (4) @(posedge clk);

    // Backpressure with four back-to-back requests
    #1 bus.out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send(4'd11, 1'b1, 8'h9A, 8'h47);
        send(4'd12, 1'b1, 8'h9A, 8'h47);
        send(4'd11, 1'b0, 8'h9A, 8'h47);
        send(4'd1, 1'b0, 8'h12, 8'h34);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("bp_accepts", acc_cnt - acc0, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        h0 = hs_cnt;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("bp_one_per_cycle", hs_cnt - h0, 4);
      end
    join
    repeat (3) @(posedge clk);

    // Reset with two transactions in flight
    #1 bus.out_ready = 1'b0;
    send(4'd0, 1'b0, 8'h11, 8'h22);
    send(4'd3, 1'b0, 8'h11, 8'h22);
    idle();
    @(posedge clk); #1;
    chk("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_drop_valid", bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    h0 = hs_cnt;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_no_stale", hs_cnt - h0, 0);

    // W=5 variant: shift amount beyond the lane width
    @(posedge clk); #1;
    bus5.in_valid = 1'b1; bus5.in_op = 4'd5; bus5.in_signed = 1'b0;
    bus5.in_a = 5'h1F; bus5.in_b = 5'd7;
    @(posedge clk); #1;
    bus5.in_op = 4'd6; bus5.in_signed = 1'b1; bus5.in_a = 5'h10; bus5.in_b = 5'd7;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    chk("w5_shl_valid", bus5.out_valid, 1);
    chk("w5_shl_y", bus5.out_y, 0);
    @(posedge clk); #1;
    chk("w5_shr_neg_y", bus5.out_y, 5'h1F);

    // Randomized traffic with random gaps and random downstream stalls
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) idle();
          send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    bus.out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
